// File: rtl/mastermind_check_ctrl.sv
// rtl/mastermind_check_ctrl.sv - Mastermind guess-check sequencer: exact and color scoring, feedback write, win/lose tracking
module mastermind_check_ctrl #(
  parameter int NUM_PEGS   = 4,
  parameter int COLOR_W    = 3,
  parameter int NUM_COLORS = 6,
  parameter int MAX_GUESS  = 6
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          start,
  input  logic [NUM_PEGS*COLOR_W-1:0]   answer,
  input  logic [NUM_PEGS*COLOR_W-1:0]   guess,
  input  logic [2:0]                    guess_num,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    exact_cnt,
  output logic [2:0]                    color_cnt,
  output logic                          fb_we,
  output logic [2:0]                    fb_row,
  output logic [5:0]                    fb_data,
  output logic                          win,
  output logic                          lose
);

  localparam int PI_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
  localparam logic [PI_W-1:0]    LAST_PEG   = PI_W'(NUM_PEGS - 1);
  localparam logic [COLOR_W-1:0] MAX_COLOR  = COLOR_W'(NUM_COLORS);
  localparam logic [2:0]         ROW_LIMIT  = 3'(MAX_GUESS);
  localparam logic [2:0]         LAST_ROW   = 3'(MAX_GUESS - 1);
  localparam logic [2:0]         ALL_PEGS   = 3'(NUM_PEGS);

  typedef enum logic [1:0] {S_IDLE, S_EXACT, S_COLOR, S_FINISH} state_t;

  state_t                        r_state;
  logic [NUM_PEGS*COLOR_W-1:0]   r_ans;
  logic [NUM_PEGS*COLOR_W-1:0]   r_guess;
  logic [2:0]                    r_row;
  logic [2:0]                    r_exact;
  logic [2:0]                    r_total;
  logic [PI_W-1:0]               r_idx;
  logic [COLOR_W-1:0]            r_color;

  logic                          w_exact_hit;
  logic [2:0]                    w_g_cnt;
  logic [2:0]                    w_a_cnt;
  logic [2:0]                    w_total_next;
  logic [2:0]                    w_color_res;
  logic                          w_accept;

  // Only colors 1..NUM_COLORS ever match, so empty and invalid pegs drop out here.
  always_comb begin
    w_exact_hit = 1'b0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (r_idx == PI_W'(i)) begin
        w_exact_hit = (r_guess[i*COLOR_W +: COLOR_W] == r_ans[i*COLOR_W +: COLOR_W]) &&
                      (r_guess[i*COLOR_W +: COLOR_W] != '0) &&
                      (r_guess[i*COLOR_W +: COLOR_W] <= MAX_COLOR);
      end
    end
  end

  always_comb begin
    w_g_cnt = '0;
    w_a_cnt = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      w_g_cnt = w_g_cnt + 3'(r_guess[i*COLOR_W +: COLOR_W] == r_color);
      w_a_cnt = w_a_cnt + 3'(r_ans[i*COLOR_W +: COLOR_W] == r_color);
    end
  end

  assign w_total_next = r_total + ((w_g_cnt < w_a_cnt) ? w_g_cnt : w_a_cnt);
  assign w_color_res  = w_total_next - r_exact;
  assign w_accept     = start && !win && !lose && (guess_num < ROW_LIMIT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_ans     <= '0;
      r_guess   <= '0;
      r_row     <= '0;
      r_exact   <= '0;
      r_total   <= '0;
      r_idx     <= '0;
      r_color   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_we     <= 1'b0;
      exact_cnt <= '0;
      color_cnt <= '0;
      fb_row    <= '0;
      fb_data   <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ans   <= answer;
            r_guess <= guess;
            r_row   <= guess_num;
            r_exact <= '0;
            r_total <= '0;
            r_idx   <= '0;
            r_color <= COLOR_W'(1);
            busy    <= 1'b1;
            r_state <= S_EXACT;
          end
        end
        S_EXACT: begin
          if (w_exact_hit) r_exact <= r_exact + 3'd1;
          if (r_idx == LAST_PEG) r_state <= S_COLOR;
          else                   r_idx   <= r_idx + PI_W'(1);
        end
        S_COLOR: begin
          r_total <= w_total_next;
          // Results are registered on the last color cycle so they are valid during FINISH.
          if (r_color == MAX_COLOR) begin
            exact_cnt <= r_exact;
            color_cnt <= w_color_res;
            fb_data   <= {w_color_res, r_exact};
            fb_row    <= r_row;
            fb_we     <= 1'b1;
            done      <= 1'b1;
            if (r_exact == ALL_PEGS)    win  <= 1'b1;
            else if (r_row == LAST_ROW) lose <= 1'b1;
            r_state   <= S_FINISH;
          end else begin
            r_color <= r_color + COLOR_W'(1);
          end
        end
        S_FINISH: begin
          done    <= 1'b0;
          fb_we   <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_check_ctrl.sv
// tb/tb_mastermind_check_ctrl.sv - Table-driven self-checking bench for mastermind_check_ctrl
module tb_mastermind_check_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] answer = '0;
  logic [11:0] guess = '0;
  logic [2:0]  guess_num = '0;
  logic        busy, done, fb_we, win, lose;
  logic [2:0]  exact_cnt, color_cnt, fb_row;
  logic [5:0]  fb_data;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  mastermind_check_ctrl dut (
    .Clk(Clk), .Reset(Reset), .start(start), .answer(answer), .guess(guess),
    .guess_num(guess_num), .busy(busy), .done(done), .exact_cnt(exact_cnt),
    .color_cnt(color_cnt), .fb_we(fb_we), .fb_row(fb_row), .fb_data(fb_data),
    .win(win), .lose(lose)
  );

  typedef struct {
    logic [11:0] ans;
    logic [11:0] gs;
    logic [2:0]  num;
    logic [2:0]  ex;
    logic [2:0]  co;
    logic        w;
    logic        l;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {13'd0, busy, done, fb_we, win, lose, exact_cnt, color_cnt, fb_row, fb_data};
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Pulses start, scrambles the inputs while busy, watches a 16-cycle window.
  task automatic run_row(input logic [11:0] a, input logic [11:0] g, input logic [2:0] n,
                         input int restart_at, output int lat, output int we_cnt,
                         output int busy_cnt, output int skew);
    lat = 0; we_cnt = 0; busy_cnt = 0; skew = 0;
    @(negedge Clk);
    answer = a; guess = g; guess_num = n; start = 1'b1;
    @(negedge Clk);
    for (int k = 1; k <= 16; k++) begin
      if (done && lat == 0) lat = k;
      if (fb_we) we_cnt++;
      if (busy) busy_cnt++;
      if (fb_we != done) skew++;
      start = (k == restart_at);
      answer = ~a; guess = ~g;
      @(negedge Clk);
    end
    start = 1'b0;
  endtask

  task automatic idle_probe(input string name, input logic [2:0] n);
    int seen;
    seen = 0;
    @(negedge Clk);
    answer = 12'h249; guess = 12'h249; guess_num = n; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (busy || done || fb_we) seen++;
      @(negedge Clk);
    end
    chk(name, seen, 0);
  endtask

  int lat, we_cnt, busy_cnt, skew;

  initial begin
    vecs[0] = '{12'h249, 12'h249, 3'd0, 3'd4, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{12'h8D1, 12'h0CA, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0};
    vecs[2] = '{12'h489, 12'h251, 3'd1, 3'd1, 3'd2, 1'b0, 1'b0};
    vecs[3] = '{12'h8D1, 12'h0CA, 3'd5, 3'd1, 3'd2, 1'b0, 1'b1};
    vecs[4] = '{12'hFFF, 12'hFFF, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0};
    vecs[5] = '{12'h000, 12'h000, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0};
    vecs[6] = '{12'h8D1, 12'h29C, 3'd4, 3'd0, 3'd4, 1'b0, 1'b0};

    do_reset();
    chk("reset_outputs", all_outs(), 32'd0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      run_row(vecs[v].ans, vecs[v].gs, vecs[v].num, 0, lat, we_cnt, busy_cnt, skew);
      chk($sformatf("v%0d_latency", v), lat, 11);
      chk($sformatf("v%0d_we_count", v), we_cnt, 1);
      chk($sformatf("v%0d_busy_cycles", v), busy_cnt, 11);
      chk($sformatf("v%0d_we_done_align", v), skew, 0);
      chk($sformatf("v%0d_exact", v), exact_cnt, vecs[v].ex);
      chk($sformatf("v%0d_color", v), color_cnt, vecs[v].co);
      chk($sformatf("v%0d_fb_row", v), fb_row, vecs[v].num);
      chk($sformatf("v%0d_fb_data", v), fb_data, {vecs[v].co, vecs[v].ex});
      chk($sformatf("v%0d_win", v), win, vecs[v].w);
      chk($sformatf("v%0d_lose", v), lose, vecs[v].l);
    end

    // After a win, further starts are ignored.
    do_reset();
    run_row(12'h249, 12'h249, 3'd0, 0, lat, we_cnt, busy_cnt, skew);
    chk("win_set", win, 1);
    idle_probe("start_after_win", 3'd1);
    chk("win_sticky", {win, lose}, 2'b10);

    // After a loss, starts are ignored until reset.
    do_reset();
    run_row(12'h8D1, 12'h0CA, 3'd5, 0, lat, we_cnt, busy_cnt, skew);
    chk("lose_set", {win, lose}, 2'b01);
    idle_probe("start_after_lose", 3'd0);
    do_reset();
    chk("lose_cleared", all_outs(), 32'd0);

    // Restart pulse while busy is dropped, not queued.
    do_reset();
    run_row(12'h8D1, 12'h0CA, 3'd2, 3, lat, we_cnt, busy_cnt, skew);
    chk("restart_latency", lat, 11);
    chk("restart_we_count", we_cnt, 1);
    chk("restart_busy_cycles", busy_cnt, 11);

    // Out-of-range row.
    do_reset();
    idle_probe("guess_num_6", 3'd6);
    idle_probe("guess_num_7", 3'd7);

    // Reset mid-check aborts without a write.
    do_reset();
    @(negedge Clk);
    answer = 12'h249; guess = 12'h249; guess_num = 3'd0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    we_cnt = 0;
    for (int k = 1; k < 5; k++) begin
      if (fb_we || done) we_cnt++;
      @(negedge Clk);
    end
    chk("midreset_busy_before", busy, 1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midreset_outputs", all_outs(), 32'd0);
    Reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (fb_we || done || busy) we_cnt++;
      @(negedge Clk);
    end
    chk("midreset_no_write", we_cnt, 0);
    run_row(12'h489, 12'h251, 3'd1, 0, lat, we_cnt, busy_cnt, skew);
    chk("post_reset_latency", lat, 11);
    chk("post_reset_result", {exact_cnt, color_cnt, fb_row}, {3'd1, 3'd2, 3'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
